// File: rtl/rr_tagged_out_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_tagged_out_queue_pkg
// Purpose  : Shared constants, entry type and width helpers for the
//            tagged output queue that follows the 4-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_tagged_out_queue_pkg;

  localparam int NSRC   = 4;
  localparam int TAGW   = $clog2(NSRC);
  localparam int DATA_W = 8;

  // One queue entry: the arbiter's chosen source plus its payload.
  typedef struct packed {
    logic [TAGW-1:0]   tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Total-occupancy counter width: must represent 0..entries inclusive.
  function automatic int count_w(input int entries);
    return $clog2(entries) + 1;
  endfunction

  // Per-source counter width: must represent 0..cap inclusive.
  function automatic int cnt_w(input int cap);
    return $clog2(cap) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/src_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : src_occupancy_counter
// Purpose  : Tracks how many queue entries one source currently holds and
//            flags when that source has reached its residency cap.
// Revision : 1.0 - initial release
// ============================================================================
module src_occupancy_counter #(
  parameter int CAP = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_at_cap
);

  logic [W-1:0] r_cnt;

  // Occupancy update; simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_cap = (r_cnt == W'(CAP));

  // The enqueue gating should make these unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    (i_inc && !i_dec) |-> (r_cnt != W'(CAP)));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    (i_dec && !i_inc) |-> (r_cnt != '0));

endmodule
`default_nettype wire

// File: rtl/rr_tagged_out_queue.sv
`default_nettype none
// ============================================================================
// Module   : rr_tagged_out_queue
// Purpose  : FIFO of {tag, data} pairs behind the round-robin arbiter, with a
//            per-source residency cap so no single source can fill the queue.
// Revision : 1.0 - initial release
// ============================================================================
module rr_tagged_out_queue
  import rr_tagged_out_queue_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int WIDTH   = 8,
  parameter int SRC_CAP = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_enq_valid,
  output logic                         io_enq_ready,
  input  logic [WIDTH-1:0]             io_enq_bits,
  input  logic [TAGW-1:0]              io_enq_tag,
  output logic                         io_deq_valid,
  input  logic                         io_deq_ready,
  output logic [WIDTH-1:0]             io_deq_bits,
  output logic [TAGW-1:0]              io_deq_tag,
  output logic [count_w(ENTRIES)-1:0]  io_count,
  output logic [NSRC-1:0]              io_src_full
);

  localparam int PW   = $clog2(ENTRIES);
  localparam int CNTW = count_w(ENTRIES);
  localparam int CW   = cnt_w(SRC_CAP);
  localparam int EW   = TAGW + WIDTH;

  logic [EW-1:0]   r_mem [ENTRIES];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  logic            w_full;
  logic            w_enq_fire;
  logic            w_deq_fire;
  logic [EW-1:0]   w_head;
  logic [NSRC-1:0] w_src_full;
  logic [CW-1:0]   w_cnt [NSRC];
  logic [CNTW-1:0] w_cnt_sum;

  // Fullness comes from the occupancy count, so wptr == rptr is unambiguous.
  assign w_full       = (r_count == CNTW'(ENTRIES));
  // Ready depends only on queue state and the offered tag, never on valid or deq_ready.
  assign io_enq_ready = !w_full && !w_src_full[io_enq_tag];
  assign io_deq_valid = (r_count != '0);
  assign w_enq_fire   = io_enq_valid && io_enq_ready;
  assign w_deq_fire   = io_deq_valid && io_deq_ready;

  assign w_head       = r_mem[r_rptr];
  assign io_deq_bits  = w_head[WIDTH-1:0];
  assign io_deq_tag   = w_head[EW-1:WIDTH];
  assign io_count     = r_count;
  assign io_src_full  = w_src_full;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_enq_fire && !reset) begin
      r_mem[r_wptr] <= {io_enq_tag, io_enq_bits};
    end
  end

  // Pointer and total-occupancy update; simultaneous enq/deq leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) r_wptr <= r_wptr + PW'(1);
      if (w_deq_fire) r_rptr <= r_rptr + PW'(1);
      if (w_enq_fire && !w_deq_fire)      r_count <= r_count + CNTW'(1);
      else if (w_deq_fire && !w_enq_fire) r_count <= r_count - CNTW'(1);
    end
  end

  // One occupancy counter per source, stepped by the tags of the two handshakes.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      src_occupancy_counter #(
        .CAP (SRC_CAP),
        .W   (CW)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_inc    (w_enq_fire && (io_enq_tag == TAGW'(gi))),
        .i_dec    (w_deq_fire && (io_deq_tag == TAGW'(gi))),
        .o_cnt    (w_cnt[gi]),
        .o_at_cap (w_src_full[gi])
      );
    end
  endgenerate

  // Sum of per-source occupancies, used only to cross-check the total count.
  always_comb begin
    w_cnt_sum = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_cnt_sum = w_cnt_sum + CNTW'(w_cnt[i]);
    end
  end

  a_cnt_sum : assert property (@(posedge clk) disable iff (reset)
    w_cnt_sum == r_count);

endmodule
`default_nettype wire

// File: tb/tb_rr_tagged_out_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_tagged_out_queue
// Purpose  : Scoreboard bench for rr_tagged_out_queue with a behavioural
//            round-robin arbiter for the upstream scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_tagged_out_queue;
  import rr_tagged_out_queue_pkg::*;

  localparam int ENTRIES = 8;
  localparam int SRC_CAP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              io_enq_valid = 1'b0;
  logic              io_enq_ready;
  logic [DATA_W-1:0] io_enq_bits = '0;
  logic [TAGW-1:0]   io_enq_tag = '0;
  logic              io_deq_valid;
  logic              io_deq_ready = 1'b0;
  logic [DATA_W-1:0] io_deq_bits;
  logic [TAGW-1:0]   io_deq_tag;
  logic [count_w(ENTRIES)-1:0] io_count;
  logic [NSRC-1:0]   io_src_full;

  int     n_checks = 0;
  int     n_errors = 0;
  entry_t sb[$];
  int     m_cnt[NSRC];
  int     exp_rr;
  int     max_res;

  always #5 clk = ~clk;

  rr_tagged_out_queue #(
    .ENTRIES (ENTRIES),
    .WIDTH   (DATA_W),
    .SRC_CAP (SRC_CAP)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_enq_tag   (io_enq_tag),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_deq_tag   (io_deq_tag),
    .io_count     (io_count),
    .io_src_full  (io_src_full)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One clock of stimulus: compare outputs against the model, then advance it.
  task automatic cycle(input logic ev, input logic [TAGW-1:0] tag, input logic [DATA_W-1:0] data,
                       input logic dr, input logic rst, input logic chk_rr, output logic enq_f);
    logic            exp_rdy;
    logic            exp_vld;
    logic            deq_f;
    logic [NSRC-1:0] exp_full;
    entry_t          e;
    @(negedge clk);
    io_enq_valid = ev;
    io_enq_tag   = tag;
    io_enq_bits  = data;
    io_deq_ready = dr;
    reset        = rst;
    #1;
    exp_rdy = (sb.size() < ENTRIES) && (m_cnt[tag] < SRC_CAP);
    exp_vld = (sb.size() != 0);
    for (int i = 0; i < NSRC; i++) exp_full[i] = (m_cnt[i] == SRC_CAP);
    check("enq_ready", {31'd0, io_enq_ready}, {31'd0, exp_rdy});
    check("deq_valid", {31'd0, io_deq_valid}, {31'd0, exp_vld});
    check("count", 32'(io_count), 32'(sb.size()));
    check("src_full", 32'(io_src_full), 32'(exp_full));
    enq_f = ev && exp_rdy;
    deq_f = dr && exp_vld;
    if (deq_f) begin
      check("deq_bits", 32'(io_deq_bits), 32'(sb[0].data));
      check("deq_tag", 32'(io_deq_tag), 32'(sb[0].tag));
      if (chk_rr) begin
        check("rr_order", 32'(io_deq_tag), 32'(exp_rr));
        exp_rr = (exp_rr + 1) % NSRC;
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
      enq_f = 1'b0;
    end else begin
      if (deq_f) begin
        e = sb.pop_front();
        m_cnt[e.tag]--;
      end
      if (enq_f) begin
        e.tag  = tag;
        e.data = data;
        sb.push_back(e);
        m_cnt[tag]++;
      end
    end
    for (int i = 0; i < NSRC; i++) if (m_cnt[i] > max_res) max_res = m_cnt[i];
  endtask

  task automatic drain(input logic chk_rr);
    logic f;
    int   guard;
    guard = 0;
    while (sb.size() > 0 && guard < 3 * ENTRIES) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, chk_rr, f);
      guard++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic            f;
    logic [TAGW-1:0] last;
    for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
    exp_rr  = 0;
    max_res = 0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);

    // Fill with rotating tags, confirm full, then drain in order
    for (int i = 0; i < 8; i++) cycle(1'b1, TAGW'(i % 4), DATA_W'(8'h10 + i), 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd0, 8'h18, 1'b0, 1'b0, 1'b0, f);
    check("full_refuses", {31'd0, f}, 32'd0);
    drain(1'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);

    // Per-source cap on tag 2
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd2, DATA_W'(8'h20 + i), 1'b0, 1'b0, 1'b0, f);
    check("cap_fifth_refused", {31'd0, f}, 32'd0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd2, 8'h25, 1'b1, 1'b0, 1'b0, f);
    check("cap_no_bypass", {31'd0, f}, 32'd0);
    cycle(1'b1, 2'd2, 8'h26, 1'b0, 1'b0, 1'b0, f);
    check("cap_after_deq", {31'd0, f}, 32'd1);
    drain(1'b0);

    // Simultaneous enq+deq at count 3: equal tags, then different tags
    cycle(1'b1, 2'd1, 8'h40, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd1, 8'h41, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd2, 8'h42, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd1, 8'h43, 1'b1, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd3, 8'h44, 1'b1, 1'b0, 1'b0, f);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);
    drain(1'b0);

    // Pointer wrap with continuous traffic at count 1
    cycle(1'b1, 2'd0, 8'h50, 1'b0, 1'b0, 1'b0, f);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, TAGW'($urandom_range(0, NSRC - 1)), DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, f);
    drain(1'b0);

    // Reset at count 5 while both handshakes fire
    for (int i = 0; i < 5; i++) cycle(1'b1, TAGW'(i % 4), DATA_W'(8'h30 + i), 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd1, 8'h99, 1'b1, 1'b1, 1'b0, f);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b1, 2'd1, 8'hAB, 1'b0, 1'b0, 1'b0, f);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, f);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, f);

    // Behavioural round-robin arbiter with all four inputs valid
    exp_rr  = 0;
    max_res = 0;
    last    = TAGW'(NSRC - 1);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, last + TAGW'(1), DATA_W'(8'h60 + i), (i % 2) == 0, 1'b0, 1'b1, f);
      if (f) last = last + TAGW'(1);
    end
    drain(1'b1);
    check("max_resident_ok", {31'd0, (max_res <= SRC_CAP)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
